// File: rtl/id_guard_axil_if.sv
// AXI4-Lite bus bundle for id_guard_axil (no wstrb/prot).
// The master modport is the bus driver and the slave modport is the register block.
interface id_guard_axil_if #(
    parameter int ADDR_WIDTH = 7
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [31:0]           wdata;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/id_guard_axil.sv
// Per-channel ID comparator with match-event counter and sticky threshold block, AXI4-Lite mapped.
// Optional ID_GUARD_IRQ_EN adds irq_o and an IRQ_MASK register at 0x7C.
module id_guard_axil #(
    parameter int NUM_CH     = 4,
    parameter int ID_WIDTH   = 24,
    parameter int CNT_WIDTH  = 8,
    parameter int ADDR_WIDTH = 7
) (
    input  logic              s00_axi_aclk,
    input  logic              s00_axi_aresetn,
    id_guard_axil_if.slave    s00_axi,
    output logic [NUM_CH-1:0] match_o,
    output logic [NUM_CH-1:0] block_o
`ifdef ID_GUARD_IRQ_EN
    ,
    output logic              irq_o
`endif
);
    localparam int WORD_W = ADDR_WIDTH - 2;
    localparam int CH_W   = ADDR_WIDTH - 4;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [31:0] BAD_DATA    = 32'hDEAD_BEEF;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic                   awready_q, arready_q, bvalid_q, rvalid_q;
    logic [1:0]             bresp_q, rresp_q;
    logic [31:0]            rdata_q, rd_mux;
    logic                   wr_en, rd_en, wr_map, rd_map;
    logic [WORD_W-1:0]      wr_word, rd_word;
    logic [NUM_CH-1:0]      wr_hit, rd_hit;
    logic [NUM_CH-1:0][31:0] ch_rdata;
    logic                   wr_irq, rd_irq;
    logic [31:0]            irq_rdata;
    logic                   unused_bits;

    assign wr_word = s00_axi.awaddr[ADDR_WIDTH-1:2];
    assign rd_word = s00_axi.araddr[ADDR_WIDTH-1:2];
    assign wr_en   = awready_q & s00_axi.awvalid & s00_axi.wvalid;
    assign rd_en   = arready_q & s00_axi.arvalid;
    assign wr_map  = (|wr_hit) | wr_irq;

    assign s00_axi.awready = awready_q;
    assign s00_axi.wready  = awready_q;
    assign s00_axi.bvalid  = bvalid_q;
    assign s00_axi.bresp   = bresp_q;
    assign s00_axi.arready = arready_q;
    assign s00_axi.rvalid  = rvalid_q;
    assign s00_axi.rresp   = rresp_q;
    assign s00_axi.rdata   = rdata_q;

    assign unused_bits = &{1'b0, s00_axi.wdata, s00_axi.awaddr[1:0], s00_axi.araddr[1:0]};

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [ID_WIDTH-1:0]  id_fixed_q, id_dyn_q;
        logic [CNT_WIDTH-1:0] thresh_q, count_q;
        logic                 match_q, match_prev_q, block_q;
        logic                 wr_sel, clear, match_event;
        logic [31:0]          rd_val;

        assign wr_hit[gi]  = (wr_word[WORD_W-1:2] == CH_W'(gi));
        assign rd_hit[gi]  = (rd_word[WORD_W-1:2] == CH_W'(gi));
        assign wr_sel      = wr_en & wr_hit[gi];
        assign clear       = wr_sel & (wr_word[1:0] == 2'd3) & s00_axi.wdata[0];
        assign match_event = match_q & ~match_prev_q;

        always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
            if (!s00_axi_aresetn) begin
                id_fixed_q   <= '0;
                id_dyn_q     <= '0;
                thresh_q     <= '0;
                count_q      <= '0;
                match_q      <= 1'b0;
                match_prev_q <= 1'b0;
                block_q      <= 1'b0;
            end else begin
                if (wr_sel && wr_word[1:0] == 2'd0) id_fixed_q <= s00_axi.wdata[ID_WIDTH-1:0];
                if (wr_sel && wr_word[1:0] == 2'd1) id_dyn_q   <= s00_axi.wdata[ID_WIDTH-1:0];
                if (wr_sel && wr_word[1:0] == 2'd2) thresh_q   <= s00_axi.wdata[CNT_WIDTH-1:0];
                match_q      <= (id_fixed_q == id_dyn_q);
                match_prev_q <= match_q;
                // A clear landing on the same edge as an event drops the event.
                if (clear)
                    count_q <= '0;
                else if (match_event && count_q != CNT_MAX)
                    count_q <= count_q + CNT_WIDTH'(1);
                if (clear)
                    block_q <= 1'b0;
                else if (thresh_q != '0 && count_q >= thresh_q)
                    block_q <= 1'b1;
            end
        end

        always_comb begin
            rd_val = '0;
            case (rd_word[1:0])
                2'd0:    rd_val = 32'(id_fixed_q);
                2'd1:    rd_val = 32'(id_dyn_q);
                2'd2:    rd_val = 32'(thresh_q);
                default: rd_val = 32'({count_q, block_q, match_q});
            endcase
        end

        assign ch_rdata[gi] = rd_val;
        assign match_o[gi]  = match_q;
        assign block_o[gi]  = block_q;
    end

`ifdef ID_GUARD_IRQ_EN
    localparam logic [WORD_W-1:0] IRQ_WORD = WORD_W'(31);
    logic [NUM_CH-1:0] irq_mask_q;
    logic              irq_q;

    assign wr_irq    = (wr_word == IRQ_WORD);
    assign rd_irq    = (rd_word == IRQ_WORD);
    assign irq_rdata = 32'(irq_mask_q);
    assign irq_o     = irq_q;

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            irq_mask_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            if (wr_en && wr_irq) irq_mask_q <= s00_axi.wdata[NUM_CH-1:0];
            irq_q <= |(block_o & irq_mask_q);
        end
    end
`else
    assign wr_irq    = 1'b0;
    assign rd_irq    = 1'b0;
    assign irq_rdata = '0;
`endif

    always_comb begin
        rd_mux = BAD_DATA;
        rd_map = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_hit[i]) begin
                rd_mux = ch_rdata[i];
                rd_map = 1'b1;
            end
        end
        if (rd_irq) begin
            rd_mux = irq_rdata;
            rd_map = 1'b1;
        end
    end

    // Ready may rise while the old response is handing off, so back-to-back writes lose no cycle.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            awready_q <= s00_axi.awvalid & s00_axi.wvalid & ~awready_q
                         & ~(bvalid_q & ~s00_axi.bready);
            if (wr_en) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_map ? RESP_OKAY : RESP_SLVERR;
            end else if (s00_axi.bready) begin
                bvalid_q <= 1'b0;
            end

            arready_q <= s00_axi.arvalid & ~arready_q & ~(rvalid_q & ~s00_axi.rready);
            if (rd_en) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_mux;
                rresp_q  <= rd_map ? RESP_OKAY : RESP_SLVERR;
            end else if (s00_axi.rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_id_guard_axil.sv
// Bench for id_guard_axil: register vector table plus hand-written corner sequences,
// responses checked by a negedge scoreboard monitor on the B and R channels.
module tb_id_guard_axil;
    localparam int NUM_CH = 4;
    localparam int ID_WIDTH = 24;
    localparam int CNT_WIDTH = 2;
    localparam int ADDR_WIDTH = 7;
    localparam int NVEC = 28;

    typedef struct {
        logic        wr;
        logic [6:0]  addr;
        logic [31:0] data;
        logic [1:0]  resp;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic [6:0]  addr;
        logic [1:0]  resp;
        logic [31:0] data;
    } rexp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NUM_CH-1:0] match_o, block_o;
`ifdef ID_GUARD_IRQ_EN
    logic irq;
`endif

    int errors = 0;
    int checks = 0;
    logic [1:0] b_q[$];
    rexp_t r_q[$];
    vec_t vecs[NVEC];

    always #5 clk = ~clk;

    id_guard_axil_if #(.ADDR_WIDTH(ADDR_WIDTH)) axi ();

    id_guard_axil #(
        .NUM_CH(NUM_CH), .ID_WIDTH(ID_WIDTH), .CNT_WIDTH(CNT_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)
    ) dut (
        .s00_axi_aclk(clk),
        .s00_axi_aresetn(rst_n),
        .s00_axi(axi),
        .match_o(match_o),
        .block_o(block_o)
`ifdef ID_GUARD_IRQ_EN
        ,
        .irq_o(irq)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (axi.bvalid && axi.bready) begin
            if (b_q.size() == 0) begin
                check("b_unexpected", 32'(axi.bvalid), 32'd0);
            end else begin
                logic [1:0] e;
                e = b_q.pop_front();
                check("bresp", 32'(axi.bresp), 32'(e));
                $display("B  resp=%0d", axi.bresp);
            end
        end
        if (axi.rvalid && axi.rready) begin
            if (r_q.size() == 0) begin
                check("r_unexpected", 32'(axi.rvalid), 32'd0);
            end else begin
                rexp_t e;
                e = r_q.pop_front();
                check($sformatf("rresp@%02h", e.addr), 32'(axi.rresp), 32'(e.resp));
                check($sformatf("rdata@%02h", e.addr), axi.rdata, e.data);
                $display("R  addr=%02h resp=%0d data=%08h", e.addr, axi.rresp, axi.rdata);
            end
        end
    end

    task automatic wait_aw();
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!axi.awready && n < 50);
        check("awready", 32'(axi.awready), 32'd1);
        check("wready", 32'(axi.wready), 32'd1);
    endtask

    task automatic wait_ar();
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!axi.arready && n < 50);
        check("arready", 32'(axi.arready), 32'd1);
    endtask

    task automatic do_write(input logic [6:0] addr, input logic [31:0] data, input logic [1:0] resp);
        b_q.push_back(resp);
        $display("W  addr=%02h data=%08h", addr, data);
        axi.awaddr = addr; axi.wdata = data;
        axi.awvalid = 1'b1; axi.wvalid = 1'b1;
        wait_aw();
        @(posedge clk); #1;
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_read(input logic [6:0] addr, input logic [1:0] resp, input logic [31:0] data);
        r_q.push_back('{addr, resp, data});
        axi.araddr = addr;
        axi.arvalid = 1'b1;
        wait_ar();
        @(posedge clk); #1;
        axi.arvalid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic bad;
        axi.awaddr = '0; axi.wdata = '0; axi.araddr = '0;
        axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.arvalid = 1'b1;
        axi.bready = 1'b1; axi.rready = 1'b1;

        vecs[0]  = '{1'b0, 7'h0C, 32'h0,        2'b00, 32'h5};
        vecs[1]  = '{1'b0, 7'h3C, 32'h0,        2'b00, 32'h5};
        vecs[2]  = '{1'b1, 7'h00, 32'h00ABCDEF, 2'b00, 32'h0};
        vecs[3]  = '{1'b0, 7'h00, 32'h0,        2'b00, 32'h00ABCDEF};
        vecs[4]  = '{1'b0, 7'h0C, 32'h0,        2'b00, 32'h4};
        vecs[5]  = '{1'b1, 7'h04, 32'h00ABCDEF, 2'b00, 32'h0};
        vecs[6]  = '{1'b0, 7'h0C, 32'h0,        2'b00, 32'h9};
        vecs[7]  = '{1'b1, 7'h04, 32'hFFABCDEF, 2'b00, 32'h0};
        vecs[8]  = '{1'b0, 7'h04, 32'h0,        2'b00, 32'h00ABCDEF};
        vecs[9]  = '{1'b0, 7'h0C, 32'h0,        2'b00, 32'h9};
        vecs[10] = '{1'b1, 7'h08, 32'hFFFFFFFF, 2'b00, 32'h0};
        vecs[11] = '{1'b0, 7'h08, 32'h0,        2'b00, 32'h3};
        vecs[12] = '{1'b1, 7'h28, 32'h2,        2'b00, 32'h0};
        vecs[13] = '{1'b0, 7'h2C, 32'h0,        2'b00, 32'h5};
        vecs[14] = '{1'b1, 7'h28, 32'h1,        2'b00, 32'h0};
        vecs[15] = '{1'b0, 7'h2C, 32'h0,        2'b00, 32'h7};
        vecs[16] = '{1'b1, 7'h2C, 32'hFE,       2'b00, 32'h0};
        vecs[17] = '{1'b0, 7'h2C, 32'h0,        2'b00, 32'h7};
        vecs[18] = '{1'b1, 7'h2C, 32'h1,        2'b00, 32'h0};
        vecs[19] = '{1'b0, 7'h2C, 32'h0,        2'b00, 32'h1};
        vecs[20] = '{1'b0, 7'h70, 32'h0,        2'b10, 32'hDEADBEEF};
        vecs[21] = '{1'b1, 7'h70, 32'hFFFFFFFF, 2'b10, 32'h0};
        vecs[22] = '{1'b0, 7'h40, 32'h0,        2'b10, 32'hDEADBEEF};
        vecs[23] = '{1'b1, 7'h50, 32'h1,        2'b10, 32'h0};
        vecs[24] = '{1'b0, 7'h10, 32'h0,        2'b00, 32'h0};
        vecs[25] = '{1'b0, 7'h18, 32'h0,        2'b00, 32'h0};
        vecs[26] = '{1'b0, 7'h0C, 32'h0,        2'b00, 32'h9};
        vecs[27] = '{1'b0, 7'h00, 32'h0,        2'b00, 32'h00ABCDEF};

        // Reset state, with valids pending to show readies stay low.
        repeat (3) @(posedge clk);
        #1;
        check("rst_match", 32'(match_o), 32'h0);
        check("rst_block", 32'(block_o), 32'h0);
        check("rst_awready", 32'(axi.awready), 32'h0);
        check("rst_arready", 32'(axi.arready), 32'h0);
        check("rst_bvalid", 32'(axi.bvalid), 32'h0);
        check("rst_rvalid", 32'(axi.rvalid), 32'h0);
        check("rst_rdata", axi.rdata, 32'h0);
        check("rst_resp", 32'({axi.bresp, axi.rresp}), 32'h0);
        axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("match_after_release", 32'(match_o), 32'hF);
        repeat (3) @(posedge clk);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].data, vecs[i].resp);
            else            do_read(vecs[i].addr, vecs[i].resp, vecs[i].exp_rdata);
        end
        check("match_after_table", 32'(match_o), 32'hF);
        check("block_after_table", 32'(block_o), 32'h0);

        // ID_DYNAMIC change reflected in match_o one cycle later.
        do_write(7'h14, 32'h5, 2'b00);
        check("ch1_mismatch", 32'(match_o[1]), 32'h0);

        // Threshold 3 on ch1, three match events.
        do_write(7'h1C, 32'h1, 2'b00);
        do_write(7'h18, 32'h3, 2'b00);
        for (int k = 0; k < 3; k++) begin
            do_write(7'h14, 32'h0, 2'b00);
            do_write(7'h14, 32'h5, 2'b00);
            if (k < 2) check("ch1_block_below", 32'(block_o[1]), 32'h0);
            else       check("ch1_block_at", 32'(block_o[1]), 32'h1);
        end
        do_write(7'h1C, 32'h1, 2'b00);
        check("ch1_block_cleared", 32'(block_o[1]), 32'h0);
        do_read(7'h1C, 2'b00, 32'h0);

        // Back-to-back: match event on ch1, then a clear landing on the counting edge.
        b_q.push_back(2'b00);
        b_q.push_back(2'b00);
        axi.awaddr = 7'h14; axi.wdata = 32'h0;
        axi.awvalid = 1'b1; axi.wvalid = 1'b1;
        wait_aw();
        @(posedge clk); #1;
        axi.awaddr = 7'h1C; axi.wdata = 32'h1;
        wait_aw();
        @(posedge clk); #1;
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        @(posedge clk); #1;
        do_read(7'h1C, 2'b00, 32'h1);
        check("ch1_block_after_clear_race", 32'(block_o[1]), 32'h0);

        // B backpressure: second write must wait until bready returns.
        axi.bready = 1'b0;
        b_q.push_back(2'b00);
        axi.awaddr = 7'h24; axi.wdata = 32'h7;
        axi.awvalid = 1'b1; axi.wvalid = 1'b1;
        wait_aw();
        @(posedge clk); #1;
        b_q.push_back(2'b00);
        axi.awaddr = 7'h24; axi.wdata = 32'h0;
        bad = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (!axi.bvalid || axi.awready) bad = 1'b1;
        end
        check("b_stall", 32'(bad), 32'h0);
        axi.bready = 1'b1;
        wait_aw();
        @(posedge clk); #1;
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        @(posedge clk); #1;
        do_read(7'h24, 2'b00, 32'h0);
        check("ch2_block_event", 32'(block_o[2]), 32'h1);

`ifdef ID_GUARD_IRQ_EN
        do_write(7'h7C, 32'h4, 2'b00);
        check("irq_set", 32'(irq), 32'h1);
        do_read(7'h7C, 2'b00, 32'h4);
        do_write(7'h7C, 32'h2, 2'b00);
        check("irq_masked", 32'(irq), 32'h0);
`else
        do_read(7'h7C, 2'b10, 32'hDEADBEEF);
        do_write(7'h7C, 32'h1, 2'b10);
`endif

        // Read and write of the same register accepted on one edge.
        r_q.push_back('{7'h00, 2'b00, 32'h00ABCDEF});
        b_q.push_back(2'b00);
        axi.araddr = 7'h00; axi.arvalid = 1'b1;
        axi.awaddr = 7'h00; axi.wdata = 32'h00123456;
        axi.awvalid = 1'b1; axi.wvalid = 1'b1;
        wait_aw();
        check("ar_with_aw", 32'(axi.arready), 32'h1);
        @(posedge clk); #1;
        axi.arvalid = 1'b0; axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_read(7'h00, 2'b00, 32'h00123456);

        // Counter saturation on ch3 (threshold 0, never blocks).
        do_write(7'h3C, 32'h1, 2'b00);
        repeat (5) begin
            do_write(7'h34, 32'h1, 2'b00);
            do_write(7'h34, 32'h0, 2'b00);
        end
        do_read(7'h3C, 2'b00, 32'hD);
        check("ch3_no_block", 32'(block_o[3]), 32'h0);

        // Reset with a read response outstanding.
        axi.rready = 1'b0;
        axi.araddr = 7'h00; axi.arvalid = 1'b1;
        wait_ar();
        @(posedge clk); #1;
        axi.arvalid = 1'b0;
        @(posedge clk); #1;
        check("rvalid_held", 32'(axi.rvalid), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("rst2_rvalid", 32'(axi.rvalid), 32'h0);
        check("rst2_rdata", axi.rdata, 32'h0);
        check("rst2_match", 32'(match_o), 32'h0);
        check("rst2_block", 32'(block_o), 32'h0);
`ifdef ID_GUARD_IRQ_EN
        check("rst2_irq", 32'(irq), 32'h0);
`endif
        axi.araddr = 7'h08; axi.arvalid = 1'b1;
        @(posedge clk); #1;
        check("rst2_arready", 32'(axi.arready), 32'h0);
        axi.arvalid = 1'b0;
        axi.rready = 1'b1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("match_after_release2", 32'(match_o), 32'hF);
        do_read(7'h08, 2'b00, 32'h0);
        do_read(7'h0C, 2'b00, 32'h5);
        do_read(7'h00, 2'b00, 32'h0);
        do_read(7'h2C, 2'b00, 32'h5);
        check("block_after_release2", 32'(block_o), 32'h0);

        repeat (3) @(posedge clk);
        #1;
        check("b_queue_empty", 32'(b_q.size()), 32'h0);
        check("r_queue_empty", 32'(r_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/id_guard_axil.md
ID_GUARD_AXIL -- requirements
Module: id_guard_axil

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent ID-compare channels (legal 1..4).
REQ-002 SHALL have parameter ID_WIDTH, default 24, compared ID width (legal 1..32).
REQ-003 SHALL have parameter CNT_WIDTH, default 8, match-event counter width (legal 1..16).
REQ-004 SHALL have parameter ADDR_WIDTH, default 7; DATA_WIDTH fixed at 32.
REQ-005 SHALL have ports: s00_axi_aclk input 1 clock; s00_axi_aresetn input 1 reset. One clock; reset is asynchronous and active-low.
REQ-006 SHALL have AXI4-Lite slave ports s00_axi_{awaddr,awvalid,awready,wdata,wvalid,wready,bresp,bvalid,bready,araddr,arvalid,arready,rdata,rresp,rvalid,rready} with standard directions and widths (addr ADDR_WIDTH, data 32, resp 2); no wstrb, no prot.
REQ-007 SHALL have port match_o output NUM_CH: registered per-channel match.
REQ-008 SHALL have port block_o output NUM_CH: per-channel sticky block flag.

Function
REQ-009 Register map per channel c at base 0x10*c: +0x0 ID_FIXED RW, +0x4 ID_DYNAMIC RW, +0x8 THRESH RW [CNT_WIDTH-1:0], +0xC STATUS.
REQ-010 STATUS read = {zero, count[CNT_WIDTH-1:0] at bits [CNT_WIDTH+1:2], block at bit1, match at bit0}; write with wdata[0]=1 clears count and block, other bits ignored.
REQ-011 ID registers store wdata[ID_WIDTH-1:0]; upper bits read as zero.
REQ-012 Write channel: awready and wready SHALL assert together, for one cycle, only when awvalid and wvalid are both high and no B response is pending; register updates on that edge.
REQ-013 bvalid SHALL assert the cycle after acceptance and hold until bready; no new write accepted while bvalid is high.
REQ-014 Read channel: arready SHALL pulse for one cycle when arvalid high and no R response pending; rdata/rresp registered, rvalid next cycle, held stable until rready.
REQ-015 Address decode uses awaddr/araddr[ADDR_WIDTH-1:2]; addresses beyond channel NUM_CH-1 and not otherwise mapped SHALL return resp 2'b10 (SLVERR), read data 0xDEADBEEF, and have no side effect; mapped accesses return 2'b00.
REQ-016 match_o[c] SHALL be registered: equals (ID_FIXED==ID_DYNAMIC) one cycle after either register changes.
REQ-017 A match event is a 0->1 transition of match_o[c]; count SHALL increment by one in the cycle after the event, saturating at 2^CNT_WIDTH-1 (no wrap).
REQ-018 block_o[c] SHALL set when THRESH!=0 and count>=THRESH, and remain set until cleared via STATUS; THRESH=0 disables blocking.
REQ-019 Lowering THRESH to <= current count SHALL set block on the next cycle.
REQ-020 Clear write and match event in the same cycle: clear wins, count=0, event dropped.
REQ-021 Simultaneous read and write to the same register: read returns pre-write value.

Reset
REQ-022 On s00_axi_aresetn low, asynchronously: all ID, THRESH, count registers =0, block_o=0, match_o=0, awready/wready/arready/bvalid/rvalid=0, bresp/rresp=0, rdata=0.
REQ-023 Reset mid-transaction SHALL abandon any pending B/R response; first cycle after release accepts new transactions.
REQ-024 Since IDs reset equal, match_o SHALL rise the first cycle after reset release and count one event per channel.

Configuration
REQ-025 Macro ID_GUARD_IRQ_EN defined: add output irq_o (1 bit, registered) = OR over c of (block_o[c] & IRQ_MASK[c]); IRQ_MASK RW at 0x7C, bits [NUM_CH-1:0], reset 0.
REQ-026 Macro undefined: irq_o port absent; 0x7C unmapped (SLVERR per REQ-015).

Verification
REQ-027 Write 0x00ABCDEF to 0x00 then 0x04 -> match_o[0]=1 one cycle after second write, STATUS 0x0C reads count=2 (reset event + this) when matching started from mismatch after an intervening 0x04 write.
REQ-028 THRESH ch1 =3, toggle ID_DYNAMIC match/mismatch 3 times -> block_o[1]=1 after third event; write 0x1 to 0x1C -> block_o[1]=0, count=0.
REQ-029 Hold bready low 10 cycles after write -> bvalid held, awready stays 0 for a second queued write; release -> second write accepted.
REQ-030 Read 0x70 with NUM_CH=4 -> rresp=2'b10, rdata=0xDEADBEEF; write there -> bresp=2'b10, no register changed.
REQ-031 CNT_WIDTH=2, 5 events -> count saturates at 3; assert reset with rvalid pending -> rvalid=0 immediately, all regs zero.
